// File: rtl/addseq_arbiter_if.sv
// Request/response bundle between NREQ requesters, the result consumer and the
// shared chunked adder (addseq_arbiter).
interface addseq_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high. A requester holds req_valid and its operands until it sees
    // its req_ready bit; the adder holds rsp_valid and the rsp_* payload
    // unchanged until rsp_ready is high.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_sub;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/addseq_arbiter.sv
// Round-robin shared CHUNK-bit adder slice doing WIDTH-bit add/sub LSB chunk first.
// Optional op counter ports enabled with `define ADDSEQ_PERF_CNT_EN.
module addseq_arbiter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int NREQ  = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    addseq_arbiter_if.slave    bus,
`ifdef ADDSEQ_PERF_CNT_EN
    input  logic               op_count_clr,
    output logic [15:0]        op_count,
`endif
    output logic [1:0]         o_dbg_state
);
    localparam int NPASS = WIDTH / CHUNK;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_rsp_valid;

    logic             w_any;
    logic [IDW-1:0]   w_sel;
    logic [WIDTH-1:0] w_cap_a;
    logic [WIDTH-1:0] w_cap_b;
    logic             w_cap_sub;
    logic [CHUNK:0]   w_chunk_full;
    logic [CHUNK-1:0] w_sum_chunk;
    logic             w_cout_chunk;
    logic             w_cmsb;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Lowest rotation distance from r_rr_ptr wins; the descending k loop lets it overwrite.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && (i == (int'(r_rr_ptr) + k) % NREQ)) begin
                    w_any = 1'b1;
                    w_sel = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        w_cap_a   = '0;
        w_cap_b   = '0;
        w_cap_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == IDW'(i)) begin
                w_cap_a   = bus.req_a[i*WIDTH +: WIDTH];
                w_cap_b   = bus.req_b[i*WIDTH +: WIDTH];
                w_cap_sub = bus.req_sub[i];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = (r_state == IDLE) && w_any && (w_sel == IDW'(i));
        end
    end

    assign w_chunk_full = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, r_carry};
    assign w_sum_chunk  = w_chunk_full[CHUNK-1:0];
    assign w_cout_chunk = w_chunk_full[CHUNK];
    // Carry into the top bit of the slice; only meaningful on the last pass.
    assign w_cmsb       = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum_chunk[CHUNK-1];
    assign w_last       = (r_cnt == CW'(NPASS - 1));

    generate
        if (WIDTH > CHUNK) begin : g_multi_pass
            assign w_sum_next = {w_sum_chunk, r_sum[WIDTH-1:CHUNK]};
        end else begin : g_single_pass
            assign w_sum_next = w_sum_chunk;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_id        <= '0;
            r_rr_ptr    <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_cap_a;
                        r_b     <= w_cap_b ^ {WIDTH{w_cap_sub}};
                        r_carry <= w_cap_sub;
                        r_id    <= w_sel;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_cout_chunk;
                    r_sum   <= w_sum_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout      <= w_cout_chunk;
                        r_ovf       <= w_cmsb ^ w_cout_chunk;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_cout;
    assign bus.rsp_ovf   = r_ovf;
    assign o_dbg_state   = r_state;

`ifdef ADDSEQ_PERF_CNT_EN
    logic [15:0] r_op_count;

    // Clear wins over a same-cycle handshake; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (op_count_clr) begin
            r_op_count <= '0;
        end else if (r_rsp_valid && bus.rsp_ready && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif
endmodule
